// File: rtl/sram_access_dp_pkg.sv
// Shared SRAM access encoding: state constants seen by the access FSM and its datapath.
package sram_access_dp_pkg;

  localparam int unsigned StateWidth = 2;

  // 2'b11 is unused by the FSM and behaves like S_IDLE without capturing.
  typedef enum logic [StateWidth-1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_SAMPLE = 2'b10,
    S_RSVD   = 2'b11
  } sram_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter; reloads on init, counts down in S_WAIT and saturates at zero.
module sram_wait_counter #(
  parameter int unsigned CNT_WIDTH   = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_i,
  input  logic dec_i,
  output logic eq0_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (init_i) begin
      count_d = CNT_WIDTH'(WAIT_STATES);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign eq0_o = (count_q == '0);

endmodule

// File: rtl/sram_access_dp.sv
// Datapath for the abus-slave SRAM access FSM: request capture, macro pin drive,
// abort tracking and a two-stage response pipeline producing a one-cycle ready pulse.
module sram_access_dp
  import sram_access_dp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                    abus_clk,
  input  logic                    abus_rstb,
  input  logic                    abus_swrite,
  input  logic                    abus_sread,
  input  logic                    abus_sabort,
  input  logic [ADDR_WIDTH-1:0]   abus_saddr,
  input  logic [DATA_WIDTH-1:0]   abus_swdata,
  input  logic [DATA_WIDTH/8-1:0] abus_swstrb,
  input  logic [StateWidth-1:0]   current_state,
  input  logic                    counter_init,
  output logic                    counter_eq0,
  output logic [DATA_WIDTH-1:0]   abus_srdata,
  output logic                    abus_sready,
  output logic                    sram_cs,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_wmask,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  sram_state_e state;
  logic        in_idle, in_wait, in_sample;
  logic        capture, access;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbWidth-1:0]  strb_q;
  logic                  is_write_q;
  logic                  abort_q, abort_d;
  logic                  p1_valid_q, p1_write_q, p2_valid_q;
  logic [DATA_WIDTH-1:0] srdata_q;

  assign state     = sram_state_e'(current_state);
  assign in_idle   = (state == S_IDLE);
  assign in_wait   = (state == S_WAIT);
  assign in_sample = (state == S_SAMPLE);
  assign capture   = in_idle & (abus_swrite | abus_sread);

  // Reset gates the macro select so an in-flight sample is dropped immediately.
  assign access = in_sample & ~(abort_q | abus_sabort) & abus_rstb;

  sram_wait_counter #(
    .CNT_WIDTH   (CNT_WIDTH),
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_counter (
    .clk_i  (abus_clk),
    .rst_ni (abus_rstb),
    .init_i (counter_init),
    .dec_i  (in_wait),
    .eq0_o  (counter_eq0)
  );

  always_comb begin
    abort_d = abort_q;
    if (capture) begin
      abort_d = abus_sabort;
    end else if ((in_wait || in_sample) && abus_sabort) begin
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      is_write_q <= 1'b0;
      abort_q    <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_write_q <= 1'b0;
      p2_valid_q <= 1'b0;
      srdata_q   <= '0;
    end else begin
      if (capture) begin
        addr_q     <= abus_saddr;
        wdata_q    <= abus_swdata;
        strb_q     <= abus_swstrb;
        is_write_q <= abus_swrite;
      end
      abort_q    <= abort_d;
      p1_valid_q <= access;
      p1_write_q <= is_write_q;
      p2_valid_q <= p1_valid_q;
      // Macro read data is valid the cycle after cs, i.e. while p1 holds the read.
      if (p1_valid_q && !p1_write_q) begin
        srdata_q <= sram_rdata;
      end
    end
  end

  assign sram_cs     = access;
  assign sram_we     = access & is_write_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;
  assign sram_wmask  = is_write_q ? strb_q : '0;
  assign abus_sready = p2_valid_q;
  assign abus_srdata = srdata_q;

endmodule

// File: tb/tb_sram_access_dp.sv
// Bench for sram_access_dp: the bench plays the access FSM and the macro, and checks every
// cycle against a transaction-level model plus a few hand-computed directed expectations.
module tb_sram_access_dp;
  import sram_access_dp_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          abus_rstb;
  logic          abus_swrite, abus_sread, abus_sabort;
  logic [AW-1:0] abus_saddr;
  logic [DW-1:0] abus_swdata;
  logic [SW-1:0] abus_swstrb;
  logic [1:0]    current_state;
  logic          counter_init;
  logic          counter_eq0;
  logic [DW-1:0] abus_srdata;
  logic          abus_sready, sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [SW-1:0] sram_wmask;
  logic [DW-1:0] sram_rdata;

  // Second instance with WAIT_STATES=3, used for the wait counter only.
  logic [1:0]    ws_state;
  logic          ws_init, ws_eq0;
  logic [DW-1:0] d3_srdata, d3_wdata;
  logic          d3_sready, d3_cs, d3_we;
  logic [AW-1:0] d3_addr;
  logic [SW-1:0] d3_wmask;

  always #5 clk = ~clk;

  sram_access_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0), .CNT_WIDTH(4)) u_dut (
    .abus_clk(clk), .abus_rstb(abus_rstb), .abus_swrite(abus_swrite), .abus_sread(abus_sread),
    .abus_sabort(abus_sabort), .abus_saddr(abus_saddr), .abus_swdata(abus_swdata),
    .abus_swstrb(abus_swstrb), .current_state(current_state), .counter_init(counter_init),
    .counter_eq0(counter_eq0), .abus_srdata(abus_srdata), .abus_sready(abus_sready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  sram_access_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3), .CNT_WIDTH(4)) u_ws3 (
    .abus_clk(clk), .abus_rstb(abus_rstb), .abus_swrite(abus_swrite), .abus_sread(abus_sread),
    .abus_sabort(abus_sabort), .abus_saddr(abus_saddr), .abus_swdata(abus_swdata),
    .abus_swstrb(abus_swstrb), .current_state(ws_state), .counter_init(ws_init),
    .counter_eq0(ws_eq0), .abus_srdata(d3_srdata), .abus_sready(d3_sready),
    .sram_cs(d3_cs), .sram_we(d3_we), .sram_addr(d3_addr), .sram_wdata(d3_wdata),
    .sram_wmask(d3_wmask), .sram_rdata(sram_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Transaction-level model state.
  int            m_cnt, m3_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_srdata;
  logic [SW-1:0] m_strb;
  bit            m_wr, m_abort;
  int            rdy_q[$];   // cycles at which a ready pulse is due
  int            cap_q[$];   // cycles whose sram_rdata becomes the read response

  bit            rand_rdata;
  int            obs_cs_n, obs_rdy;
  logic          obs_we;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata;
  logic [SW-1:0] obs_wmask;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m3_cnt = 0; m_addr = '0; m_wdata = '0; m_srdata = '0; m_strb = '0;
    m_wr = 1'b0; m_abort = 1'b0;
    rdy_q.delete();
    cap_q.delete();
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic cyc_step();
    bit e_cs, e_rdy;
    if (rand_rdata) sram_rdata = $urandom;
    #2;
    e_cs  = (current_state == S_SAMPLE) && !(m_abort || abus_sabort) && abus_rstb;
    e_rdy = (rdy_q.size() > 0) && (rdy_q[0] == cyc);
    chk("counter_eq0", counter_eq0, m_cnt == 0);
    chk("counter_eq0_ws3", ws_eq0, m3_cnt == 0);
    chk("sram_cs", sram_cs, e_cs);
    chk("sram_we", sram_we, e_cs && m_wr);
    chk("sram_addr", sram_addr, m_addr);
    chk("sram_wdata", sram_wdata, m_wdata);
    chk("sram_wmask", sram_wmask, m_wr ? m_strb : '0);
    chk("abus_srdata", abus_srdata, m_srdata);
    chk("abus_sready", abus_sready, e_rdy);
    if (abus_sready) obs_rdy = cyc;
    if (sram_cs) begin
      obs_cs_n++; obs_we = sram_we; obs_addr = sram_addr;
      obs_wdata = sram_wdata; obs_wmask = sram_wmask;
    end
    @(posedge clk);
    if (abus_rstb) begin
      if (e_rdy) rdy_q.delete(0);
      if ((cap_q.size() > 0) && (cap_q[0] == cyc)) begin
        m_srdata = sram_rdata;
        cap_q.delete(0);
      end
      // A completed sample answers two cycles later; reads take the macro data one cycle later.
      if (e_cs) begin
        rdy_q.push_back(cyc + 2);
        if (!m_wr) cap_q.push_back(cyc + 1);
      end
      if (counter_init) m_cnt = 0;
      else if ((current_state == S_WAIT) && (m_cnt != 0)) m_cnt = m_cnt - 1;
      if (ws_init) m3_cnt = 3;
      else if ((ws_state == S_WAIT) && (m3_cnt != 0)) m3_cnt = m3_cnt - 1;
      if ((current_state == S_IDLE) && (abus_swrite || abus_sread)) begin
        m_addr = abus_saddr; m_wdata = abus_swdata; m_strb = abus_swstrb;
        m_wr = abus_swrite; m_abort = abus_sabort;
      end else if (((current_state == S_WAIT) || (current_state == S_SAMPLE)) && abus_sabort) begin
        m_abort = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic xfer(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] sb, input bit ab_wait, input bit ab_samp,
                      input int trail);
    int guard;
    obs_cs_n = 0; obs_rdy = -1;
    current_state = S_IDLE; counter_init = 1'b1; abus_sabort = 1'b0;
    abus_swrite = wr; abus_sread = rd; abus_saddr = a; abus_swdata = d; abus_swstrb = sb;
    cyc_step();
    counter_init = 1'b0;
    // Bus inputs wander after capture; only the captured values may reach the macro.
    abus_saddr = AW'($urandom); abus_swdata = $urandom; abus_swstrb = SW'($urandom);
    if (wr || rd) begin
      guard = 0;
      do begin
        current_state = S_WAIT; abus_sabort = ab_wait;
        abus_swrite = 1'($urandom_range(1)); abus_sread = 1'($urandom_range(1));
        cyc_step();
        guard++;
      end while ((m_cnt != 0) && (guard < 40));
      current_state = S_SAMPLE; abus_sabort = ab_samp;
      cyc_step();
    end
    abus_swrite = 1'b0; abus_sread = 1'b0;
    for (int i = 0; i < trail; i++) begin
      current_state = S_IDLE; counter_init = 1'b1; abus_sabort = 1'($urandom_range(1));
      cyc_step();
    end
    abus_sabort = 1'b0;
  endtask

  initial begin
    int n0;
    abus_rstb = 1'b0; abus_swrite = 1'b0; abus_sread = 1'b0; abus_sabort = 1'b0;
    abus_saddr = '0; abus_swdata = '0; abus_swstrb = '0; current_state = S_IDLE;
    counter_init = 1'b0; sram_rdata = '0; ws_state = S_IDLE; ws_init = 1'b0;
    rand_rdata = 1'b0; obs_cs_n = 0; obs_rdy = -1;
    model_clear();
    @(negedge clk);
    cyc_step();
    cyc_step();
    abus_rstb = 1'b1;

    // Read 0x05 returning 0xDEADBEEF.
    sram_rdata = 32'hDEADBEEF; n0 = cyc;
    xfer(1'b0, 1'b1, 10'h005, 32'h0, 4'h0, 1'b0, 1'b0, 2);
    chk("rd_cs_count", obs_cs_n, 1);
    chk("rd_we", obs_we, 0);
    chk("rd_addr", obs_addr, 10'h005);
    chk("rd_ready_cycle", obs_rdy, n0 + 4);
    chk("rd_srdata", abus_srdata, 32'hDEADBEEF);

    // Write 0x3FF; read data must stay.
    sram_rdata = 32'h0BAD0BAD; n0 = cyc;
    xfer(1'b1, 1'b0, 10'h3FF, 32'h12345678, 4'b0101, 1'b0, 1'b0, 2);
    chk("wr_we", obs_we, 1);
    chk("wr_addr", obs_addr, 10'h3FF);
    chk("wr_wmask", obs_wmask, 4'b0101);
    chk("wr_wdata", obs_wdata, 32'h12345678);
    chk("wr_ready_cycle", obs_rdy, n0 + 4);
    chk("wr_srdata_kept", abus_srdata, 32'hDEADBEEF);

    // Abort during wait, then a clean read of 0x10.
    xfer(1'b0, 1'b1, 10'h020, 32'h0, 4'h0, 1'b1, 1'b0, 3);
    chk("abort_no_cs", obs_cs_n, 0);
    chk("abort_no_ready", obs_rdy, -1);
    sram_rdata = 32'hCAFEF00D;
    xfer(1'b0, 1'b1, 10'h010, 32'h0, 4'h0, 1'b0, 1'b0, 2);
    chk("after_abort_addr", obs_addr, 10'h010);
    chk("after_abort_srdata", abus_srdata, 32'hCAFEF00D);

    // Write and read together act as a write.
    xfer(1'b1, 1'b1, 10'h022, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 2);
    chk("both_we", obs_we, 1);
    chk("both_srdata_kept", abus_srdata, 32'hCAFEF00D);

    // Wait counter with WAIT_STATES=3.
    ws_init = 1'b1; cyc_step(); ws_init = 1'b0; ws_state = S_WAIT;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ws3_low", ws_eq0, 0);
      cyc_step();
    end
    #1 chk("ws3_high", ws_eq0, 1);
    cyc_step();
    #1 chk("ws3_no_wrap", ws_eq0, 1);
    ws_state = S_IDLE; ws_init = 1'b1; cyc_step(); ws_init = 1'b0;
    #1 chk("ws3_reload", ws_eq0, 0);
    cyc_step();

    // Randomized traffic, including back-to-back transfers and the unused state code.
    rand_rdata = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(7) == 0) begin
        current_state = 2'b11; counter_init = 1'($urandom_range(1));
        abus_swrite = 1'($urandom_range(1)); abus_sread = 1'($urandom_range(1));
        abus_sabort = 1'($urandom_range(1)); abus_saddr = AW'($urandom);
        abus_swdata = $urandom; abus_swstrb = SW'($urandom);
        cyc_step();
      end
      xfer(1'($urandom_range(1)), 1'($urandom_range(1)), AW'($urandom), $urandom, SW'($urandom),
           $urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(2));
    end
    xfer(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 3);

    // Reset asserted in the sample cycle of a read.
    rand_rdata = 1'b0; sram_rdata = 32'h55AA55AA;
    xfer(1'b0, 1'b1, 10'h0F0, 32'h0, 4'h0, 1'b0, 1'b0, 2);
    current_state = S_IDLE; counter_init = 1'b1; abus_sread = 1'b1; abus_saddr = 10'h007;
    ws_init = 1'b1;
    cyc_step();
    abus_sread = 1'b0; counter_init = 1'b0; ws_init = 1'b0; current_state = S_WAIT;
    cyc_step();
    current_state = S_SAMPLE; abus_rstb = 1'b0; model_clear();
    #1;
    chk("rst_cs", sram_cs, 0);
    chk("rst_eq0_ws3", ws_eq0, 1);
    chk("rst_srdata", abus_srdata, 0);
    obs_cs_n = 0; obs_rdy = -1;
    cyc_step();
    abus_rstb = 1'b1; current_state = S_IDLE; counter_init = 1'b1;
    for (int i = 0; i < 4; i++) cyc_step();
    chk("rst_no_ready", obs_rdy, -1);
    chk("rst_no_cs", obs_cs_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_access_dp.md
Name: sram_access_dp

Overview:
- Datapath and wait-state companion to the SRAM access state machine on the abus slave side.
- Generates the wait-state counter flag the state machine branches on.
- Captures address, write data and strobes when a request is accepted; drives the synchronous single-port SRAM macro pins in the sample state.
- Returns read data and a one-cycle ready pulse to the bus, with abort suppression.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- WAIT_STATES, 0, extra wait cycles loaded into the counter; must fit CNT_WIDTH.
- CNT_WIDTH, 4, wait counter width.

Ports:
- abus_clk  input  1  clock.
- abus_rstb  input  1  asynchronous active-low reset.
- abus_swrite  input  1  write request, sampled in S_IDLE.
- abus_sread  input  1  read request, sampled in S_IDLE.
- abus_sabort  input  1  abort of the outstanding transfer.
- abus_saddr  input  ADDR_WIDTH  word address.
- abus_swdata  input  DATA_WIDTH  write data.
- abus_swstrb  input  DATA_WIDTH/8  byte write strobes.
- current_state  input  2  state from the access state machine.
- counter_init  input  1  counter reload, high in S_IDLE.
- counter_eq0  output  1  wait counter is zero.
- abus_srdata  output  DATA_WIDTH  read data.
- abus_sready  output  1  one-cycle completion pulse.
- sram_cs  output  1  macro chip select.
- sram_we  output  1  macro write enable.
- sram_addr  output  ADDR_WIDTH  macro address.
- sram_wdata  output  DATA_WIDTH  macro write data.
- sram_wmask  output  DATA_WIDTH/8  macro byte mask, 1 = write byte.
- sram_rdata  input  DATA_WIDTH  macro read data, valid the cycle after cs.

Behaviour:
- Clock and reset: single clock abus_clk. Reset abus_rstb is asynchronous, active-low.
  - All flops clear on reset: counter to 0, capture registers to 0, abort flag to 0, response pipeline to 0, abus_srdata to 0.
  - Outputs during reset: counter_eq0=1, abus_sready=0, sram_cs=0, sram_we=0, sram_addr/wdata/wmask=0.
- Encoding: state constants come from the shared SRAM encoding header: S_IDLE=2'b00, S_WAIT=2'b01, S_SAMPLE=2'b10. 2'b11 is treated as S_IDLE-like: no capture, no SRAM access.
- Wait counter:
  - counter_init=1: load WAIT_STATES.
  - Else if current_state==S_WAIT and count!=0: decrement.
  - Otherwise hold. No wrap below 0.
  - counter_eq0 is combinational, (count==0).
- Capture: in S_IDLE with (abus_swrite|abus_sread), register addr, wdata, swstrb and is_write.
  - is_write = abus_swrite; write wins if both are high.
  - The abort flag is cleared on capture, unless abus_sabort is also high that cycle, in which case it is set.
- Abort:
  - The flag is set by abus_sabort in S_WAIT or S_SAMPLE, and in the capture cycle as above.
  - In S_SAMPLE the effective abort is (flag | abus_sabort). When it is set, sram_cs=0 and no ready pulse is generated for that transfer.
  - abus_sabort in S_IDLE with no request, or in the response cycles, is ignored.
- SRAM drive (combinational from state and capture registers):
  - In S_SAMPLE without abort: sram_cs=1, sram_we=is_write, sram_addr=captured addr, sram_wdata=captured wdata.
  - sram_wmask = captured strb for writes, 0 for reads.
  - Outside S_SAMPLE: cs=0 and we=0; addr, wdata and wmask hold the captured values.
- Response: a 2-stage pipeline (p1, p2) carrying valid and is_write.
  - p1 is set at the end of the non-aborted S_SAMPLE.
  - If p1 is a read, sram_rdata is registered into abus_srdata at the end of the p1 cycle.
  - abus_sready = p2 valid, for exactly one cycle, for both reads and writes.
  - abus_srdata holds its value until the next read completes; writes do not disturb it.
- Latency: request seen in S_IDLE at cycle N → S_WAIT at N+1 (+WAIT_STATES) → S_SAMPLE → sready 2 cycles after S_SAMPLE. With WAIT_STATES=0: sready at N+4.
- Back-to-back: a new capture may happen while p1/p2 are in flight. Capture registers and the response pipeline are independent. Consecutive sready pulses are at least 3 cycles apart.
- Reset mid-operation clears everything. No ready pulse and no SRAM access for the interrupted transfer.

Decomposition:
- Shared encoding header: state constants S_IDLE/S_WAIT/S_SAMPLE and the state width.
- Sub-module sram_wait_counter: counter plus counter_eq0, parameterised by CNT_WIDTH and WAIT_STATES.
- Capture, drive and response logic stays in sram_access_dp.

Test Plan:
- Read, WAIT_STATES=0, addr 0x05, macro returns 0xDEADBEEF → single cs pulse with we=0 and addr 0x05; sready at N+4 with srdata 0xDEADBEEF.
- Write addr 0x3FF, wdata 0x12345678, strb 4'b0101 → cs=1, we=1, wmask 4'b0101, wdata 0x12345678; sready at N+4; srdata unchanged.
- WAIT_STATES=3, driving current_state as S_WAIT for 3 cycles → counter_eq0 low for 3 cycles, then high; reload on S_IDLE.
- sabort during S_WAIT → no cs in S_SAMPLE, no sready. A following read of 0x10 completes normally.
- swrite and sread both high → treated as a write (we=1).
- abus_rstb low in the S_SAMPLE cycle → cs drops immediately, no sready, counter_eq0=1, srdata=0.
